seq_mult_param: RTL and testbench

- Parametrised sequential shift-add multiplier; next generation of the team's combinational 4-bit multiplier.
- Adds configurable operand width, a runtime signed/unsigned mode, and a start/busy/done handshake.
- Sits behind the top-level pin wrapper. The operands and product are registered, so one small datapath serves any width, trading area for latency.

---
 rtl/seq_mult_pkg.sv | 17 +
 rtl/seq_mult_param_if.sv | 23 ++
 rtl/seq_mult_param_sign_adj.sv | 12 +
 rtl/seq_mult_param.sv | 115 +++++++++++
 tb/tb_seq_mult_param.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential multiplier: FSM state encoding and counter sizing.
// Pure declarations; no latency and no flow control.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // The counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_param_if.sv
// Request/result bundle between the pin wrapper (master) and the multiplier (slave).
// Latency and flow control belong to the modules; start is accepted only while busy is low.
interface seq_mult_param_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     Product_o;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, Product_o
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, Product_o
    );
endinterface

// File: rtl/seq_mult_param_sign_adj.sv
// Conditional two's-complement negate: gives |x| when neg is the sign bit, or -x on request.
// Combinational, zero latency, no flow control.
module mult_sign_adj #(
    parameter int W = 8
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;
endmodule

// File: rtl/seq_mult_param.sv
// Shift-add multiplier, unsigned or two's complement; WIDTH+2 cycles from the start edge to done.
// One op at a time: start is ignored while busy, with no queuing.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    seq_mult_param_if.slave    bus
);
    localparam int PW = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      prod_q, prod_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [PW-1:0]      acc_fixed;

    mult_sign_adj #(.W(WIDTH)) u_abs_a (
        .val (bus.A),
        .neg (bus.signed_mode & bus.A[WIDTH-1]),
        .res (a_mag)
    );

    mult_sign_adj #(.W(WIDTH)) u_abs_b (
        .val (bus.B),
        .neg (bus.signed_mode & bus.B[WIDTH-1]),
        .res (b_mag)
    );

    mult_sign_adj #(.W(PW)) u_fix (
        .val (acc_q),
        .neg (neg_q),
        .res (acc_fixed)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        prod_d   = prod_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                // The pass at cnt==WIDTH adds nothing (multiplier is already
                // shifted out); it sets the WIDTH+2 start-to-done latency.
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                prod_d  = acc_fixed;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.Product_o = prod_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Randomized and directed checks of seq_mult_param at WIDTH=8 and WIDTH=4 against an arithmetic model.
module tb_seq_mult_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    seq_mult_param_if #(.WIDTH(8)) if8 ();
    seq_mult_param_if #(.WIDTH(4)) if4 ();

    seq_mult_param #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst_n), .bus(if8));
    seq_mult_param #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst_n), .bus(if4));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Product as the mathematical rule states it, reduced to 2*w bits.
    function automatic longint ref_prod(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic sm);
        longint mask = (longint'(1) << w) - 1;
        longint av = longint'(a) & mask;
        longint bv = longint'(b) & mask;
        if (sm && av[w-1]) av = av - (longint'(1) << w);
        if (sm && bv[w-1]) bv = bv - (longint'(1) << w);
        return (av * bv) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? if8.busy : if4.busy;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? if8.done : if4.done;
    endfunction

    function automatic longint get_prod(input int w);
        return (w == 8) ? longint'(if8.Product_o) : longint'(if4.Product_o);
    endfunction

    task automatic drive(input int w, input logic st, input logic sm, input logic [15:0] a,
                         input logic [15:0] b);
        if (w == 8) begin
            if8.start = st; if8.signed_mode = sm; if8.A = a[7:0]; if8.B = b[7:0];
        end else begin
            if4.start = st; if4.signed_mode = sm; if4.A = a[3:0]; if4.B = b[3:0];
        end
    endtask

    // Present one request for one edge, then scramble the operands.
    task automatic start_op(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b);
        drive(w, 1'b1, sm, a, b);
        @(posedge clk); #1;
        drive(w, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // Entered just after the accepting edge; follows the op until busy drops.
    task automatic wait_result(input int w, input longint exp, input string tag);
        int  busy_n = 0;
        int  done_n = 0;
        int  lat = -1;
        bit  fin = 0;
        for (int i = 0; i < 64 && !fin; i++) begin
            if (get_done(w)) begin
                done_n++;
                if (lat < 0) begin
                    lat = i;
                    chk({tag, "_prod"}, get_prod(w), exp);
                end
            end
            if (get_busy(w)) busy_n++;
            else fin = 1;
            if (!fin) begin @(posedge clk); #1; end
        end
        chk({tag, "_finished"}, longint'(fin), 1);
        chk({tag, "_latency"}, longint'(lat), longint'(w + 2));
        chk({tag, "_done_pulses"}, longint'(done_n), 1);
        chk({tag, "_busy_cycles"}, longint'(busy_n), longint'(w + 3));
    endtask

    initial begin
        logic [15:0] a, b;
        logic        sm;
        longint      held;
        int          n, done_n;
        bit          seen;

        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(4, 1'b0, 1'b0, 16'd0, 16'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy8", if8.busy, 0);
        chk("rst_done8", if8.done, 0);
        chk("rst_prod8", if8.Product_o, 0);
        chk("rst_busy4", if4.busy, 0);
        chk("rst_prod4", if4.Product_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned maximum
        start_op(8, 1'b0, 16'd255, 16'd255);
        wait_result(8, 65025, "u255x255");

        // Signed corners
        start_op(8, 1'b1, 16'h80, 16'h80);
        wait_result(8, 16'h4000, "s_min_sq");
        start_op(8, 1'b1, 16'hFD, 16'd7);
        wait_result(8, 16'hFFEB, "s_m3x7");
        start_op(8, 1'b1, 16'd0, 16'hFB);
        wait_result(8, 0, "s_0xm5");

        // Start held high throughout a run with changing operands
        drive(8, 1'b1, 1'b0, 16'd13, 16'd11);
        @(posedge clk); #1;
        seen = 0; n = 0;
        while (!seen && n < 40) begin
            drive(8, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
            if (if8.done) seen = 1;
            else begin @(posedge clk); #1; n++; end
        end
        chk("hs_done_seen", longint'(seen), 1);
        chk("hs_first_ops", if8.Product_o, 143);
        @(posedge clk); #1;
        chk("hs_ignored_in_done", if8.busy, 0);
        drive(8, 1'b1, 1'b0, 16'd9, 16'd7);
        @(posedge clk); #1;
        chk("hs_accept_after_done", if8.busy, 1);
        drive(8, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        wait_result(8, 63, "hs_next");

        // Random WIDTH=8 traffic
        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom); b = 16'($urandom); sm = 1'($urandom);
            start_op(8, sm, a, b);
            wait_result(8, ref_prod(8, a, b, sm), "rnd8");
        end

        // Hold: idle with operands toggling
        held = longint'(if8.Product_o);
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            drive(8, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
            @(posedge clk); #1;
            if (if8.done) done_n++;
            if (k == 19) chk("hold_prod", if8.Product_o, held);
        end
        chk("hold_no_done", longint'(done_n), 0);

        // Exhaustive WIDTH=4, both modes
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    start_op(4, 1'(m), 16'(x), 16'(y));
                    wait_result(4, ref_prod(4, 16'(x), 16'(y), 1'(m)), m ? "exh_s" : "exh_u");
                end
            end
        end

        // Asynchronous reset in the middle of a run
        start_op(8, 1'b0, 16'd200, 16'd100);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", if8.busy, 0);
        chk("arst_done", if8.done, 0);
        chk("arst_prod", if8.Product_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_n = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (if8.done) done_n++;
        end
        chk("arst_no_done", longint'(done_n), 0);
        start_op(8, 1'b1, 16'h7F, 16'h81);
        wait_result(8, ref_prod(8, 16'h7F, 16'h81, 1'b1), "arst_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
